// File: rtl/instruction_loader_if.sv
// Byte-stream / RAM-write bus between the program source, the instruction loader and the instruction store.
// The master modport is the source side and the slave modport is the loader side.
interface instruction_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  iStart;
    logic [7:0]            iByte;
    logic                  iByteValid;
    logic                  oByteReady;
    logic                  oWriteEnable;
    logic [ADDR_WIDTH-1:0] oWriteAddress;
    logic [27:0]           oWriteData;
    logic                  oCpuHold;
    logic                  oDone;
    logic                  oError;

    modport master (
        output iStart, iByte, iByteValid,
        input  oByteReady, oWriteEnable, oWriteAddress, oWriteData, oCpuHold, oDone, oError
    );

    modport slave (
        input  iStart, iByte, iByteValid,
        output oByteReady, oWriteEnable, oWriteAddress, oWriteData, oCpuHold, oDone, oError
    );
endinterface

// File: rtl/instruction_loader.sv
// Packs a length-prefixed byte stream into 28-bit words and writes them to sequential RAM addresses.
// Define LOADER_CHECKSUM_EN to consume and verify a trailing XOR checksum byte.
module instruction_loader #(
    parameter int ADDR_WIDTH   = 16,
    parameter int BASE_ADDRESS = 0,
    parameter int MAX_WORDS    = 256
) (
    input  logic                 Clock,
    input  logic                 Reset,
    instruction_loader_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDRESS);
    localparam logic [16:0]           MAXW = 17'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR, CHECK} state_t;
    localparam state_t FINISH = CHECK;
`else
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR} state_t;
    localparam state_t FINISH = DONE;
`endif

    state_t                state, nxt;
    logic [15:0]           len;
    logic [15:0]           wcnt;
    logic [1:0]            bidx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [27:0]           wdata;
    logic                  rdy;
    logic                  accept;
    logic [15:0]           len_in;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            chk;
`endif

    assign accept = bus.iByteValid & rdy;
    assign len_in = {len[15:8], bus.iByte};

    always_ff @(posedge Clock) begin
        if (!Reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        rdy = 1'b0;
        case (state)
            IDLE, DONE, ERROR: if (bus.iStart) nxt = LEN_HI;
            LEN_HI: begin
                rdy = 1'b1;
                if (accept) nxt = LEN_LO;
            end
            LEN_LO: begin
                rdy = 1'b1;
                if (accept) begin
                    if (len_in == 16'd0)           nxt = FINISH;
                    else if ({1'b0, len_in} > MAXW) nxt = ERROR;
                    else                            nxt = DATA;
                end
            end
            DATA: begin
                rdy = 1'b1;
                if (accept && bidx == 2'd3) nxt = WRITE;
            end
            WRITE: nxt = (wcnt + 16'd1 == len) ? FINISH : DATA;
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                rdy = 1'b1;
                if (accept) nxt = (bus.iByte == chk) ? DONE : ERROR;
            end
`endif
            default: nxt = IDLE;
        endcase
    end

    // Byte 0 of each word carries only a nibble; the word is assembled in place so it is stable during the strobe.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            len   <= '0;
            wcnt  <= '0;
            bidx  <= '0;
            addr  <= BASE;
            wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk   <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERROR: if (bus.iStart) begin
                    wcnt <= '0;
                    bidx <= '0;
                    addr <= BASE;
`ifdef LOADER_CHECKSUM_EN
                    chk  <= '0;
`endif
                end
                LEN_HI: if (accept) len[15:8] <= bus.iByte;
                LEN_LO: if (accept) len[7:0]  <= bus.iByte;
                DATA: if (accept) begin
                    bidx <= bidx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk  <= chk ^ bus.iByte;
`endif
                    case (bidx)
                        2'd0:    wdata[27:24] <= bus.iByte[3:0];
                        2'd1:    wdata[23:16] <= bus.iByte;
                        2'd2:    wdata[15:8]  <= bus.iByte;
                        default: wdata[7:0]   <= bus.iByte;
                    endcase
                end
                WRITE: begin
                    addr <= addr + ADDR_WIDTH'(1);
                    wcnt <= wcnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.oByteReady    = rdy;
    assign bus.oWriteEnable  = (state == WRITE);
    assign bus.oWriteAddress = addr;
    assign bus.oWriteData    = wdata;
    assign bus.oCpuHold      = (state != IDLE) && (state != DONE);
    assign bus.oDone         = (state == DONE);
    assign bus.oError        = (state == ERROR);
endmodule

// File: tb/tb_instruction_loader.sv
// Directed and randomized loads of instruction_loader checked against a word-list reference model.
module tb_instruction_loader;
    localparam int AW   = 16;
    localparam int BASE = 0;
    localparam int MAXW = 256;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [AW-1:0] wq_addr[$];
    logic [27:0]   wq_data[$];

    instruction_loader_if #(.ADDR_WIDTH(AW)) bus();

    instruction_loader #(.ADDR_WIDTH(AW), .BASE_ADDRESS(BASE), .MAX_WORDS(MAXW)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture every strobe; the loader must never offer to take a byte while writing.
    always @(negedge clk) begin
        if (bus.oWriteEnable === 1'b1) begin
            wq_addr.push_back(bus.oWriteAddress);
            wq_data.push_back(bus.oWriteData);
            check("ready_during_write", {31'b0, bus.oByteReady}, 32'd0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Random idle gaps carry junk bytes and stray iStart pulses, both of which must be ignored.
    task automatic send(input logic [7:0] b, input int gap);
        int tries = 0;
        while ($urandom_range(99) < gap) begin
            bus.iByteValid = 1'b0;
            bus.iByte      = 8'($urandom);
            bus.iStart     = 1'($urandom_range(1));
            tick();
        end
        bus.iStart     = 1'b0;
        bus.iByteValid = 1'b1;
        bus.iByte      = b;
        while (bus.oByteReady !== 1'b1 && tries < 50) begin
            tick();
            tries++;
        end
        if (tries >= 50) check("byte_timeout", {31'b0, bus.oByteReady}, 32'd1);
        tick();
        bus.iByteValid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {31'b0, bus.oByteReady},   32'd0);
        check({tag, "_we"},    {31'b0, bus.oWriteEnable}, 32'd0);
        check({tag, "_addr"},  32'(bus.oWriteAddress),    32'(BASE));
        check({tag, "_data"},  32'(bus.oWriteData),       32'd0);
        check({tag, "_hold"},  {31'b0, bus.oCpuHold},     32'd0);
        check({tag, "_done"},  {31'b0, bus.oDone},        32'd0);
        check({tag, "_err"},   {31'b0, bus.oError},       32'd0);
    endtask

    // Streams the length, payload and (if enabled) checksum, then compares against the model.
    task automatic feed(input logic [15:0] n, input logic [7:0] data[$], input logic [7:0] chk_byte,
                        input int gap, input string tag);
        logic [7:0]  x = 8'h00;
        int          exp_writes;
        bit          exp_err;
        logic [27:0] w;
        send(n[15:8], gap);
        send(n[7:0], gap);
        if (int'(n) <= MAXW) begin
            foreach (data[i]) send(data[i], gap);
            if (CHK_EN) send(chk_byte, gap);
        end
        tick(3);
        foreach (data[i]) x ^= data[i];
        exp_err    = (int'(n) > MAXW) || (CHK_EN && chk_byte != x);
        exp_writes = (int'(n) > MAXW) ? 0 : int'(n);
        check({tag, "_nwrites"}, wq_addr.size(), exp_writes);
        for (int i = 0; i < exp_writes && i < wq_addr.size(); i++) begin
            w = {data[4*i][3:0], data[4*i+1], data[4*i+2], data[4*i+3]};
            check($sformatf("%s_addr%0d", tag, i), 32'(wq_addr[i]), 32'(BASE + i));
            check($sformatf("%s_data%0d", tag, i), 32'(wq_data[i]), 32'(w));
        end
        check({tag, "_done"}, {31'b0, bus.oDone},    {31'b0, !exp_err});
        check({tag, "_err"},  {31'b0, bus.oError},   {31'b0, exp_err});
        check({tag, "_hold"}, {31'b0, bus.oCpuHold}, {31'b0, exp_err});
    endtask

    // Start is raised alongside the first length byte; that byte must not be eaten by the start cycle.
    task automatic run_load(input logic [15:0] n, input logic [7:0] data[$], input logic [7:0] chk_byte,
                            input int gap, input string tag);
        wq_addr.delete();
        wq_data.delete();
        bus.iStart     = 1'b1;
        bus.iByteValid = 1'b1;
        bus.iByte      = n[15:8];
        tick();
        bus.iStart = 1'b0;
        check({tag, "_start_hold"}, {31'b0, bus.oCpuHold}, 32'd1);
        feed(n, data, chk_byte, gap, tag);
    endtask

    function automatic logic [7:0] xor_all(input logic [7:0] data[$]);
        logic [7:0] x = 8'h00;
        foreach (data[i]) x ^= data[i];
        return x;
    endfunction

    initial begin
        logic [7:0] d[$];
        logic [7:0] c;
        int         n;

        bus.iStart = 1'b0; bus.iByte = 8'h00; bus.iByteValid = 1'b0;
        rst_n = 1'b0;
        tick(3);
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        d = '{8'h0C, 8'h00, 8'h0F, 8'hA0};
        run_load(16'd1, d, 8'hA3, 0, "t1");

        d.delete();
        for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
        run_load(16'd3, d, xor_all(d), 40, "t2");

        d.delete();
        for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
        run_load(16'd2, d, xor_all(d) ^ 8'h01, 10, "t3");

        d.delete();
        run_load(16'h0101, d, 8'h00, 0, "t4");
        wq_addr.delete(); wq_data.delete();
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        check("t4_restart_err",   {31'b0, bus.oError},     32'd0);
        check("t4_restart_ready", {31'b0, bus.oByteReady}, 32'd1);
        check("t4_restart_hold",  {31'b0, bus.oCpuHold},   32'd1);
        d = '{8'h12, 8'h34, 8'h56, 8'h78};
        feed(16'd1, d, xor_all(d), 0, "t4b");

        // Reset lands after the second byte of the second word.
        wq_addr.delete(); wq_data.delete();
        bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send(8'h00, 0);
        send(8'h02, 0);
        foreach (d[i]) send(d[i], 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_values("t5");
        bus.iByteValid = 1'b1;
        bus.iByte      = 8'h07;
        tick(5);
        bus.iByteValid = 1'b0;
        check("t5_nwrites", wq_addr.size(), 32'd1);
        d = '{8'h0A, 8'hBC, 8'hDE, 8'hF0};
        run_load(16'd1, d, xor_all(d), 0, "t5b");

        d.delete();
        run_load(16'd0, d, 8'h00, 0, "t6");

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            d.delete();
            for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
            c = xor_all(d);
            if ($urandom_range(99) < 30) c ^= 8'($urandom_range(1, 255));
            run_load(16'(n), d, c, 30, $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
